// File: rtl/crom_arbiter_if.sv
// Requester-side bus of the CROM arbiter.
//   req    : per-requester read request, bit i = requester i
//   addr   : packed ROM addresses, requester i at [i*AW +: AW]
//   gnt    : one-hot (or zero) grant, same cycle as req
//   rvalid : one-hot return strobe, LAT cycles after the grant
//   rdata  : ROM data, broadcast to all requesters
// The master modport is the controller side; the slave modport is the arbiter side.
interface crom_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 10,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/crom_arbiter.sv
// Round-robin arbiter sharing one single-port twiddle ROM between NREQ FFT
// controllers. One grant per cycle, combinational from req and the priority
// pointer; the one-hot grant is delayed LAT cycles to tag the returning data.
// Ports:
//   clk, rstn      : clock (rising edge), async active-low reset
//   bus            : requester bus (req/addr in, gnt/rvalid/rdata out)
//   rom_en         : ROM read enable (any request pending)
//   rom_addr       : address of the winning requester, 0 when idle
//   rom_data       : ROM read data, valid LAT cycles after rom_en
//   conflict_cnt   : saturating count of cycles with >=2 requests pending
module crom_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 10,
  parameter int DW   = 32,
  parameter int LAT  = 1,
  parameter int CW   = 16
) (
  input  logic           clk,
  input  logic           rstn,
  crom_arbiter_if.slave  bus,
  output logic           rom_en,
  output logic [AW-1:0]  rom_addr,
  input  logic [DW-1:0]  rom_data,
  output logic [CW-1:0]  conflict_cnt
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]              ptr;
  logic [PW-1:0]              win;
  logic [PW-1:0]              idx;
  logic                       found;
  logic [NREQ-1:0]            gnt;
  logic                       multi;
  logic [LAT-1:0][NREQ-1:0]   vld_pipe;

  // Scan ptr, ptr+1, ... modulo NREQ; first pending request wins. The
  // explicit modulo keeps the wrap correct for non-power-of-2 NREQ.
  always_comb begin
    win   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt      = '0;
    rom_addr = '0;
    if (found) gnt[win] = 1'b1;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) rom_addr = bus.addr[i*AW +: AW];
  end

  assign rom_en     = found;
  assign bus.gnt    = gnt;
  assign bus.rvalid = vld_pipe[LAT-1];
  assign bus.rdata  = rom_data;
  assign multi      = $countones(bus.req) > 1;

  // Pointer moves just past the winner so it gets lowest priority next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ptr <= '0;
    else if (found)
      ptr <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
  end

  // Grant tags ride alongside the ROM read; reset drops in-flight returns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= gnt;
      for (int k = 1; k < LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      conflict_cnt <= '0;
    else if (multi && conflict_cnt != '1)
      conflict_cnt <= conflict_cnt + 1'b1;
  end
endmodule
